// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
// The state enum, default parameter values and the counter-width helper live here.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam int DEF_NUM_DOMAINS  = 5;
  localparam int DEF_RST_HOLD     = 16;
  localparam int DEF_LOCK_FILTER  = 64;
  localparam int DEF_LOCK_TIMEOUT = 65535;
  localparam int DEF_STAGGER      = 4;

  localparam int RETRY_W   = 4;
  localparam int RETRY_MAX = 15;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the i_clk domain.
// Both stages clear on a synchronous active-high reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a filtered lock,
// then releases the per-domain resets one at a time, retrying on lock timeout.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
  parameter int RST_HOLD     = DEF_RST_HOLD,
  parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int STAGGER      = DEF_STAGGER
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   reinit_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   ready,
  output logic                   lock_err,
  output logic [RETRY_W-1:0]     retry_cnt
);

  localparam int REL_MAX = (NUM_DOMAINS - 1) * STAGGER;
  localparam int HOLD_W  = cnt_width(RST_HOLD - 1);
  localparam int TO_W    = cnt_width(LOCK_TIMEOUT - 1);
  localparam int FLT_W   = cnt_width(LOCK_FILTER - 1);
  localparam int REL_W   = cnt_width(REL_MAX);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(LOCK_FILTER - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(REL_MAX);

  state_e                 r_state;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [FLT_W-1:0]       r_flt_cnt;
  logic [REL_W-1:0]       r_rel_cnt;
  logic                   r_pll_rst;
  logic [NUM_DOMAINS-1:0] r_dom_rst;
  logic                   r_ready;
  logic                   r_lock_err;
  logic [RETRY_W-1:0]     r_retry_cnt;

  state_e                 w_state_nxt;
  logic [HOLD_W-1:0]      w_hold_cnt_nxt;
  logic [TO_W-1:0]        w_to_cnt_nxt;
  logic [FLT_W-1:0]       w_flt_cnt_nxt;
  logic [REL_W-1:0]       w_rel_cnt_nxt;
  logic                   w_pll_rst_nxt;
  logic [NUM_DOMAINS-1:0] w_dom_rst_nxt;
  logic                   w_ready_nxt;
  logic                   w_lock_err_nxt;
  logic [RETRY_W-1:0]     w_retry_cnt_nxt;
  logic                   w_timeout;
  logic                   w_locked_s;

  sync_2ff u_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;

    unique case (r_state)
      ST_HOLD: begin
        if (!reinit_req && (r_hold_cnt == HOLD_LAST)) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (reinit_req)                 w_state_nxt = ST_HOLD;
        else if (w_locked_s)            w_state_nxt = ST_FILTER;
        else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = ST_HOLD;
          w_timeout   = 1'b1;
        end
      end
      ST_FILTER: begin
        if (reinit_req)                 w_state_nxt = ST_HOLD;
        else if (!w_locked_s)           w_state_nxt = ST_WAIT_LOCK;
        else if (r_flt_cnt == FLT_LAST) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (reinit_req || !w_locked_s)  w_state_nxt = ST_HOLD;
        else if (r_rel_cnt == REL_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (reinit_req || !w_locked_s)  w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_HOLD;
    endcase

    // Counters only advance while staying in their own state; any entry starts them from zero.
    w_hold_cnt_nxt = (r_state == ST_HOLD && w_state_nxt == ST_HOLD && !reinit_req)
                     ? r_hold_cnt + HOLD_W'(1) : '0;
    w_to_cnt_nxt   = (r_state == ST_WAIT_LOCK && w_state_nxt == ST_WAIT_LOCK)
                     ? r_to_cnt + TO_W'(1) : '0;
    w_flt_cnt_nxt  = (r_state == ST_FILTER && w_state_nxt == ST_FILTER)
                     ? r_flt_cnt + FLT_W'(1) : '0;
    w_rel_cnt_nxt  = (r_state == ST_RELEASE && w_state_nxt == ST_RELEASE)
                     ? r_rel_cnt + REL_W'(1) : '0;

    w_pll_rst_nxt = (w_state_nxt == ST_HOLD);
    w_ready_nxt   = (w_state_nxt == ST_RUN);

    w_dom_rst_nxt = '1;
    if (w_state_nxt == ST_RUN) begin
      w_dom_rst_nxt = '0;
    end else if (w_state_nxt == ST_RELEASE) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        w_dom_rst_nxt[i] = (w_rel_cnt_nxt < REL_W'(i * STAGGER));
      end
    end

    w_lock_err_nxt  = r_lock_err | w_timeout;
    w_retry_cnt_nxt = r_retry_cnt;
    if (w_timeout && (r_retry_cnt != RETRY_W'(RETRY_MAX))) begin
      w_retry_cnt_nxt = r_retry_cnt + RETRY_W'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_to_cnt    <= '0;
      r_flt_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_pll_rst   <= 1'b1;
      r_dom_rst   <= '1;
      r_ready     <= 1'b0;
      r_lock_err  <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_flt_cnt   <= w_flt_cnt_nxt;
      r_rel_cnt   <= w_rel_cnt_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_dom_rst   <= w_dom_rst_nxt;
      r_ready     <= w_ready_nxt;
      r_lock_err  <= w_lock_err_nxt;
      r_retry_cnt <= w_retry_cnt_nxt;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign dom_rst   = r_dom_rst;
  assign ready     = r_ready;
  assign lock_err  = r_lock_err;
  assign retry_cnt = r_retry_cnt;

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 5, number of clock-domain resets sequenced (one per PLL output clock).
REQ-002 SHALL have parameter RST_HOLD, default 16, refclk cycles that pll_rst is held high per attempt.
REQ-003 SHALL have parameter LOCK_FILTER, default 64, consecutive synchronized-lock cycles required before lock is accepted.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65535, WAIT_LOCK cycles allowed before a retry.
REQ-005 SHALL have parameter STAGGER, default 4, cycles between successive domain reset releases.
REQ-006 SHALL have ports: refclk  in  1  sole clock; one clock only, all logic on its rising edge.
REQ-007 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-008 SHALL have ports: pll_locked  in  1  PLL lock indication, asynchronous to refclk.
REQ-009 SHALL have ports: reinit_req  in  1  single-cycle request to restart the PLL.
REQ-010 SHALL have ports: pll_rst  out  1  reset to the PLL, registered.
REQ-011 SHALL have ports: dom_rst  out  NUM_DOMAINS  per-domain reset, active-high, registered.
REQ-012 SHALL have ports: ready  out  1  all domains out of reset and lock stable.
REQ-013 SHALL have ports: lock_err  out  1  sticky, set on any lock timeout.
REQ-014 SHALL have ports: retry_cnt  out  4  number of timeouts, saturating at 15.

Function
REQ-015 SHALL synchronize pll_locked through two flops to locked_s; all decisions use locked_s only.
REQ-016 SHALL implement states HOLD, WAIT_LOCK, FILTER, RELEASE, RUN.
REQ-017 In HOLD, SHALL drive pll_rst=1 and dom_rst all ones, and SHALL go to WAIT_LOCK after exactly RST_HOLD cycles.
REQ-018 In WAIT_LOCK, SHALL drive pll_rst=0, go to FILTER when locked_s=1, and go to HOLD when the timeout counter reaches LOCK_TIMEOUT.
REQ-019 On timeout, SHALL set lock_err and increment retry_cnt, saturating at 15; the retry continues indefinitely.
REQ-020 In FILTER, SHALL go to RELEASE after LOCK_FILTER consecutive cycles of locked_s=1; any locked_s=0 SHALL return it to WAIT_LOCK with the filter and timeout counters cleared.
REQ-021 In RELEASE, dom_rst[0] SHALL clear on the first RELEASE cycle edge, and dom_rst[i] SHALL clear exactly i*STAGGER cycles after dom_rst[0]; release order SHALL be index 0 upward.
REQ-022 The FSM SHALL enter RUN one cycle after dom_rst[NUM_DOMAINS-1] clears; ready SHALL be 1 only in RUN.
REQ-023 In RELEASE or RUN, locked_s=0 SHALL move the FSM to HOLD; on the next edge ready=0, dom_rst all ones and pll_rst=1.
REQ-024 reinit_req=1 in any state other than HOLD SHALL move the FSM to HOLD; in HOLD it SHALL restart the hold counter.
REQ-025 If reinit_req and lock loss occur together, the result SHALL be identical to a single HOLD entry.
REQ-026 reinit_req SHALL NOT change lock_err or retry_cnt.
REQ-027 Counter widths SHALL be sized by $clog2 of their parameter, and counters SHALL never wrap.

Reset
REQ-028 On rst=1, SHALL set state=HOLD with the hold counter cleared, pll_rst=1, dom_rst all ones, ready=0, lock_err=0, retry_cnt=0, and both synchronizer flops to 0.
REQ-029 rst asserted mid-sequence SHALL take priority over all inputs in the same cycle.

Structure
REQ-030 Package pll_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-031 Synchronizer SHALL be sub-module sync_2ff, instantiated once.
REQ-032 All outputs SHALL be driven directly from flops.

Verification (RST_HOLD=4, LOCK_FILTER=8, STAGGER=2, LOCK_TIMEOUT=100, NUM_DOMAINS=5)
REQ-033 Release rst, pll_locked high from cycle 10 -> pll_rst high exactly 4 cycles; dom_rst bits clear at 2-cycle spacing, 0 to 4; ready rises after the last bit, dom_rst=0.
REQ-034 pll_locked held low -> WAIT_LOCK times out after 100 cycles, pll_rst pulses 4 cycles, lock_err=1, retry_cnt=1; after 16 timeouts retry_cnt=15.
REQ-035 pll_locked glitches low 1 cycle during FILTER -> FSM returns to WAIT_LOCK, no dom_rst bit clears, then relocks normally.
REQ-036 In RUN, drop pll_locked -> within 3 cycles ready=0, dom_rst=5'b11111, pll_rst=1, lock_err unchanged.
REQ-037 reinit_req pulse during RELEASE, with dom_rst=5'b11100 -> all bits reassert next edge, full sequence repeats, retry_cnt unchanged.
REQ-038 rst asserted during RELEASE -> all outputs at reset values on the next edge.
